led_pulse_stretcher: RTL

Output-side counterpart to input debouncing. Debouncing suppresses short input changes; this block stretches each short event into a blink long enough to see. Each rising edge on i_Event produces one LED blink of fixed on-time, followed by a fixed off-gap. Events that arrive while a blink is in progress are queued in a saturating pending counter, so every event stays visible as a distinct blink. Sits between core logic (or a debounced switch output) and a GoBoard LED pin.

---
 rtl/led_pulse_stretcher_pkg.sv | 20 ++
 rtl/led_pulse_stretcher_rising_edge_detect.sv | 23 ++
 rtl/led_pulse_stretcher.sv | 136 +++++++++++++
 3 files changed

// File: rtl/led_pulse_stretcher_pkg.sv
// Shared LED/IO constants: FSM encodings and sizing helpers.
// Future LED blocks reuse these encodings.
package led_pulse_stretcher_pkg;

    localparam logic [1:0] LED_ST_IDLE = 2'd0;
    localparam logic [1:0] LED_ST_ON   = 2'd1;
    localparam logic [1:0] LED_ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = LED_ST_IDLE,
        ST_ON   = LED_ST_ON,
        ST_GAP  = LED_ST_GAP
    } led_state_e;

    // Larger of two positive counts, used to size shared timers.
    function automatic int max_cnt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_rising_edge_detect.sv
// One-cycle pulse on each 0->1 transition of i_Sig.
// History register clears on reset, so a high input after release is an edge.
module rising_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Edge
);

    logic prev_q;

    // Remember last cycle's input level.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= i_Sig;
        end
    end

    assign o_Edge = i_Sig & ~prev_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches each rising edge of i_Event into a visible LED blink.
// Events arriving mid-blink queue in a saturating pending counter.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int c_ON_CYCLES  = 250000,
    parameter int c_GAP_CYCLES = 250000,
    parameter int c_PEND_WIDTH = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_Event,
    output logic                    o_LED,
    output logic                    o_Busy,
    output logic [c_PEND_WIDTH-1:0] o_Pending,
    output logic                    o_Overflow
);

    localparam int TW = $clog2(max_cnt(c_ON_CYCLES, c_GAP_CYCLES) + 1);
    localparam logic [TW-1:0] ON_LOAD  = TW'(c_ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(c_GAP_CYCLES - 1);

    logic                    edge_w;
    led_state_e              state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [c_PEND_WIDTH-1:0] pend_q, pend_d;
    logic                    led_q, led_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;
    logic                    start;
    logic                    take_edge;
    logic                    take_pend;

    rising_edge_detect u_edge (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_Event),
        .o_Edge  (edge_w)
    );

    // Next-state: blink sequencing, then queue bookkeeping.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pend_d    = pend_q;
        led_d     = led_q;
        busy_d    = busy_q;
        ovf_d     = 1'b0;
        start     = 1'b0;
        take_edge = 1'b0;
        take_pend = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (edge_w || (pend_q != '0)) begin
                    start = 1'b1;
                end
            end
            ST_ON: begin
                if (timer_q == '0) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LOAD;
                    led_d   = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    if (edge_w || (pend_q != '0)) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                led_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // A fresh edge is shown before anything already queued.
        if (start) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
            led_d   = 1'b1;
            busy_d  = 1'b1;
            if (edge_w) begin
                take_edge = 1'b1;
            end else begin
                take_pend = 1'b1;
            end
        end

        if (edge_w && !take_edge) begin
            if (&pend_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (take_pend) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // State and registered outputs; reset drops any blink and queue.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_LED      = led_q;
    assign o_Busy     = busy_q;
    assign o_Pending  = pend_q;
    assign o_Overflow = ovf_q;

endmodule
